// File: rtl/ustream_pkg.sv
// Shared types and helpers for the unary-stream window controller.
//   state_e  : controller state encoding
//   eff_len  : maps a window length field to its effective cycle count
//              (a zero field selects the full 2^bw window)
package ustream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result is wide enough for any bw up to 16; callers cast to their width.
  function automatic logic [16:0] eff_len(input logic [15:0] len, input int unsigned bw);
    logic [16:0] r;
    if (len == 16'd0) r = 17'd1 << bw;
    else              r = {1'b0, len};
    return r;
  endfunction

endpackage

// File: rtl/ucnt_sync.sv
// Up-counter with clear and enable, synchronous active-low reset.
//   clk   : clock
//   rst_n : synchronous reset, active-low
//   en    : count up by one
//   clr   : load zero (wins over en)
//   cnt   : current count
module ucnt_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ustream_win_ctrl.sv
// Window controller for unary/stochastic bitstream evaluation. Accepts a
// window request, enables the downstream datapath for L cycles while counting
// ones on iBit, then offers the count with a valid/ready handshake.
//   iClk, iRstN         : clock, synchronous active-low reset
//   iStartVld/oStartRdy : window request handshake, iLen = length (0 -> 2^BITWIDTH)
//   iBit                : bitstream sample, counted while oEn=1
//   iAbort              : return to IDLE from any state, highest priority
//   oEn, oClr           : datapath counter enable / clear (clear on accept)
//   oBusy               : window running or result pending
//   oResVld/iResRdy/oRes: result handshake and ones count
//
// state | meaning
// IDLE  | waiting for a request; last result still visible on oRes
// RUN   | window active, counting cycles and ones
// DONE  | result presented, waiting for iResRdy
module ustream_win_ctrl
  import ustream_pkg::*;
#(
  parameter int BITWIDTH = 4
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStartVld,
  output logic                oStartRdy,
  input  logic [BITWIDTH-1:0] iLen,
  input  logic                iBit,
  input  logic                iAbort,
  output logic                oEn,
  output logic                oClr,
  output logic                oBusy,
  output logic                oResVld,
  input  logic                iResRdy,
  output logic [BITWIDTH:0]   oRes
);

  localparam int CW = BITWIDTH + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] ones_cnt;
  logic          accept;
  logic          run_go;
  logic          last_cycle;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // cyc_cnt counts completed window edges; this edge is the last when it
  // brings the count up to L.
  assign last_cycle = (cyc_cnt + CW'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (accept) len_d = CW'(eff_len(16'(iLen), BITWIDTH));
    if (iAbort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (iStartVld)  state_d = RUN;
        RUN:     if (last_cycle) state_d = DONE;
        DONE:    if (iResRdy)    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    oStartRdy = 1'b0;
    oEn       = 1'b0;
    oBusy     = 1'b0;
    oResVld   = 1'b0;
    case (state_q)
      IDLE: oStartRdy = 1'b1;
      RUN: begin
        oEn   = 1'b1;
        oBusy = 1'b1;
      end
      DONE: begin
        oResVld = 1'b1;
        oBusy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = iStartVld & oStartRdy & ~iAbort;
  assign oClr   = accept;

  // An abort edge must not advance either counter, so the ones count seen on
  // oRes is frozen at its pre-abort value.
  assign run_go = (state_q == RUN) & ~iAbort;

  ucnt_sync #(.WIDTH(CW)) u_cyc_cnt (
    .clk   (iClk),
    .rst_n (iRstN),
    .en    (run_go),
    .clr   (accept | iAbort),
    .cnt   (cyc_cnt)
  );

  ucnt_sync #(.WIDTH(CW)) u_ones_cnt (
    .clk   (iClk),
    .rst_n (iRstN),
    .en    (run_go & iBit),
    .clr   (accept),
    .cnt   (ones_cnt)
  );

  assign oRes = ones_cnt;

endmodule

// File: tb/tb_ustream_win_ctrl.sv
module tb_ustream_win_ctrl;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic       iStartVld;
  logic       oStartRdy;
  logic [3:0] iLen;
  logic       iBit;
  logic       iAbort;
  logic       oEn;
  logic       oClr;
  logic       oBusy;
  logic       oResVld;
  logic       iResRdy;
  logic [4:0] oRes;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  ustream_win_ctrl #(.BITWIDTH(4)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iStartVld (iStartVld),
    .oStartRdy (oStartRdy),
    .iLen      (iLen),
    .iBit      (iBit),
    .iAbort    (iAbort),
    .oEn       (oEn),
    .oClr      (oClr),
    .oBusy     (oBusy),
    .oResVld   (oResVld),
    .iResRdy   (iResRdy),
    .oRes      (oRes)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Monitor: pops the expected count on every completed result handshake.
  initial begin
    forever begin
      @(negedge iClk);
      if (iRstN && oResVld && iResRdy && !iAbort) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %0d expected none", oRes);
        end else begin
          chk("result", int'(oRes), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Issues a request in the current (IDLE) cycle, drives bits LSB first, and
  // returns at the negedge of the first DONE cycle.
  task automatic do_window(input int len_field, input logic [15:0] bits, input int exp_ones);
    int L;
    int en_cnt;
    int clr_cnt;
    L = (len_field == 0) ? 16 : len_field;
    iStartVld = 1'b1;
    iLen      = 4'(len_field);
    @(negedge iClk);
    chk("accept_rdy", int'(oStartRdy), 1);
    chk("accept_clr", int'(oClr), 1);
    exp_q.push_back(exp_ones);
    step();
    iStartVld = 1'b0;
    en_cnt  = 0;
    clr_cnt = 0;
    for (int i = 0; i < L; i++) begin
      iBit = bits[i];
      @(negedge iClk);
      if (oEn) en_cnt++;
      if (oClr) clr_cnt++;
      step();
    end
    iBit = 1'b0;
    chk("en_cycles", en_cnt, L);
    chk("clr_in_run", clr_cnt, 0);
    @(negedge iClk);
    chk("resvld_latency", int'(oResVld), 1);
    chk("en_off_in_done", int'(oEn), 0);
  endtask

  initial begin
    int vld_seen;
    iRstN = 1'b0; iStartVld = 1'b0; iLen = 4'd0; iBit = 1'b0;
    iAbort = 1'b0; iResRdy = 1'b1;
    step(); step();
    iRstN = 1'b1;
    @(negedge iClk);
    chk("rst_startrdy", int'(oStartRdy), 1);
    chk("rst_en", int'(oEn), 0);
    chk("rst_clr", int'(oClr), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_resvld", int'(oResVld), 0);
    chk("rst_res", int'(oRes), 0);
    step();

    // basic window: bits 1,0,1,1,0 -> 3
    do_window(5, 16'b01101, 3);
    step();
    @(negedge iClk);
    chk("idle_after_hs", int'(oStartRdy), 1);
    chk("idle_res_held", int'(oRes), 3);
    chk("idle_resvld", int'(oResVld), 0);
    step();

    // full window, no wrap
    do_window(0, 16'hFFFF, 16);
    step();

    // backpressure with starts ignored
    iResRdy = 1'b0;
    do_window(3, 16'b101, 2);
    step();
    iStartVld = 1'b1;
    iLen = 4'd4;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge iClk);
      chk("bp_startrdy", int'(oStartRdy), 0);
      chk("bp_clr", int'(oClr), 0);
      chk("bp_resvld", int'(oResVld), 1);
      chk("bp_res_stable", int'(oRes), 2);
      step();
    end
    iResRdy = 1'b1;
    step();
    do_window(4, 16'b1110, 3);
    step();
    iStartVld = 1'b0;

    // abort in 3rd RUN cycle of an 8-cycle window: ones seen so far = 1
    iStartVld = 1'b1; iLen = 4'd8;
    step();
    iStartVld = 1'b0;
    iBit = 1'b1; step();
    iBit = 1'b0; step();
    iBit = 1'b1; iAbort = 1'b1;
    step();
    iAbort = 1'b0; iBit = 1'b0;
    @(negedge iClk);
    chk("abort_idle", int'(oStartRdy), 1);
    chk("abort_en", int'(oEn), 0);
    chk("abort_busy", int'(oBusy), 0);
    chk("abort_res_kept", int'(oRes), 1);
    vld_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      if (oResVld) vld_seen++;
    end
    chk("abort_no_resvld", vld_seen, 0);
    step();

    // abort beats result handshake in DONE
    iResRdy = 1'b0;
    do_window(2, 16'b01, 1);
    chk("done_res", int'(oRes), exp_q.pop_front());
    step();
    iResRdy = 1'b1; iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    @(negedge iClk);
    chk("abort_done_idle", int'(oStartRdy), 1);
    chk("abort_done_resvld", int'(oResVld), 0);
    chk("abort_done_res", int'(oRes), 1);
    step();

    // abort beats start in IDLE
    iStartVld = 1'b1; iAbort = 1'b1; iLen = 4'd3;
    @(negedge iClk);
    chk("abort_start_clr", int'(oClr), 0);
    step();
    iStartVld = 1'b0; iAbort = 1'b0;
    @(negedge iClk);
    chk("abort_start_idle", int'(oStartRdy), 1);
    chk("abort_start_en", int'(oEn), 0);
    step();

    // reset mid-RUN
    iStartVld = 1'b1; iLen = 4'd6;
    step();
    iStartVld = 1'b0; iBit = 1'b1;
    step(); step();
    iRstN = 1'b0;
    step();
    iRstN = 1'b1; iBit = 1'b0;
    @(negedge iClk);
    chk("midrst_startrdy", int'(oStartRdy), 1);
    chk("midrst_en", int'(oEn), 0);
    chk("midrst_busy", int'(oBusy), 0);
    chk("midrst_resvld", int'(oResVld), 0);
    chk("midrst_res", int'(oRes), 0);
    step();
    do_window(2, 16'b11, 2);
    step();
    step();

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
